// File: rtl/motor_pulse_conditioner_if.sv
// Signal bundle between the raw wheel sensor / trip control and the
// conditioned event outputs that feed the mileage and time stages.
//
// Event semantics: there is no valid/ready back-pressure on this bus.
// pulse_edge, dist_tick and wait_tick are single-cycle strobes that are
// valid for exactly the one clk cycle in which they are high. The consumer
// must sample them every cycle. moving, stopped, frac_cnt and state_dbg
// are levels that are valid on every cycle. motor is asynchronous.
// enable is synchronous to clk.
interface motor_pulse_conditioner_if #(
    parameter int FRAC_W = 4
);
    logic              motor;
    logic              enable;
    logic              pulse_edge;
    logic              dist_tick;
    logic              wait_tick;
    logic              moving;
    logic              stopped;
    logic [FRAC_W-1:0] frac_cnt;
    logic [1:0]        state_dbg;

    // The sensor and trip control side drives motor and enable.
    modport master (
        output motor, enable,
        input  pulse_edge, dist_tick, wait_tick, moving, stopped, frac_cnt, state_dbg
    );

    // The conditioner consumes motor and enable and produces the events.
    modport slave (
        input  motor, enable,
        output pulse_edge, dist_tick, wait_tick, moving, stopped, frac_cnt, state_dbg
    );
endinterface

// File: rtl/motor_pulse_conditioner.sv
// Taximeter front end: synchronises and debounces the wheel sensor, then
// emits per-pulse edges, per-unit distance ticks and stationary wait ticks.
module motor_pulse_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSES_PER_UNIT = 10,
    parameter int STALL_CYCLES    = 1000,
    parameter int WAIT_DIV        = 1000
) (
    input logic                      clk,
    input logic                      rst,
    motor_pulse_conditioner_if.slave bus
);
    localparam int STAB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FRAC_W  = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1;
    localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam int WAIT_W  = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;

    localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FRAC_W-1:0]  FRAC_MAX  = FRAC_W'(PULSES_PER_UNIT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(WAIT_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STOPPED = 2'd1,
        MOVING  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   deb_q, deb_d;
    logic                   deb_prev_q, deb_prev_d;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic                   pulse_edge_q, pulse_edge_d;
    logic                   dist_tick_q, dist_tick_d;
    logic [FRAC_W-1:0]      frac_q, frac_d;
    logic [STALL_W-1:0]     stall_q, stall_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   wait_tick_q, wait_tick_d;
    logic                   moving_q, moving_d;
    logic                   stopped_q, stopped_d;
    logic                   sync_m;
    logic                   stay_stopped;

    assign sync_m = sync_q[SYNC_STAGES-1];

    // Front end: synchroniser shift, debounce, rising-edge detect and unit counting.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.motor};
        deb_d      = deb_q;
        stab_d     = '0;
        deb_prev_d = deb_q;
        if (sync_m != deb_q) begin
            if (stab_q == STAB_MAX) begin
                deb_d = ~deb_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
        // Edges are only reported while a trip is running.
        pulse_edge_d = deb_q & ~deb_prev_q & bus.enable;
        // dist_tick is registered alongside pulse_edge so both rise together.
        dist_tick_d  = pulse_edge_d && (frac_q == FRAC_MAX);
        frac_d       = frac_q;
        if (!bus.enable) begin
            frac_d = '0;
        end else if (pulse_edge_d) begin
            frac_d = (frac_q == FRAC_MAX) ? '0 : frac_q + 1'b1;
        end
    end

    // FSM next state: dropping enable wins; a coincident edge beats the stall timeout.
    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = STOPPED;
                STOPPED: if (pulse_edge_q) state_d = MOVING;
                MOVING:  if (!pulse_edge_q && (stall_q == STALL_MAX)) state_d = STOPPED;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: state decodes, stall counter and wait divider.
    always_comb begin
        moving_d     = (state_d == MOVING);
        stopped_d    = (state_d == STOPPED);
        stay_stopped = (state_q == STOPPED) && (state_d == STOPPED);
        stall_d      = '0;
        if ((state_q == MOVING) && (state_d == MOVING) && !pulse_edge_q) begin
            stall_d = stall_q + 1'b1;
        end
        wait_d = '0;
        if (stay_stopped) begin
            wait_d = (wait_q == WAIT_MAX) ? '0 : wait_q + 1'b1;
        end
        // An edge about to be reported means the cab is moving, so no wait tick.
        wait_tick_d = stay_stopped && (wait_q == WAIT_MAX) && !pulse_edge_d;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q       <= '0;
            deb_q        <= 1'b0;
            deb_prev_q   <= 1'b0;
            stab_q       <= '0;
            pulse_edge_q <= 1'b0;
            dist_tick_q  <= 1'b0;
            frac_q       <= '0;
            stall_q      <= '0;
            wait_q       <= '0;
            wait_tick_q  <= 1'b0;
            moving_q     <= 1'b0;
            stopped_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_prev_d;
            stab_q       <= stab_d;
            pulse_edge_q <= pulse_edge_d;
            dist_tick_q  <= dist_tick_d;
            frac_q       <= frac_d;
            stall_q      <= stall_d;
            wait_q       <= wait_d;
            wait_tick_q  <= wait_tick_d;
            moving_q     <= moving_d;
            stopped_q    <= stopped_d;
        end
    end

    assign bus.pulse_edge = pulse_edge_q;
    assign bus.dist_tick  = dist_tick_q;
    assign bus.wait_tick  = wait_tick_q;
    assign bus.moving     = moving_q;
    assign bus.stopped    = stopped_q;
    assign bus.frac_cnt   = frac_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: doc/motor_pulse_conditioner.md
Name: motor_pulse_conditioner

Overview:
- Front end of the taximeter.
- Takes the raw wheel/motor sensor line and produces clean, single-cycle events for the mileage and time stages:
  - a synchronised, debounced edge per wheel pulse;
  - a distance tick per PULSES_PER_UNIT pulses;
  - a wait tick while the trip is running and the cab is stationary.
- Replaces direct use of the raw motor input by the distance and time counters.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on motor (minimum 2).
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced level changes (minimum 1).
- PULSES_PER_UNIT, 10: wheel pulses per distance unit (minimum 1).
- STALL_CYCLES, 1000: clocks with no pulse edge before MOVING falls to STOPPED.
- WAIT_DIV, 1000: clocks per wait_tick while STOPPED (1 s at 1 kHz).

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- motor, input, 1: raw wheel sensor; asynchronous and may bounce.
- enable, input, 1: trip running (flag down). Synchronous to clk.
- pulse_edge, output, 1: one-cycle pulse per debounced rising edge of motor.
- dist_tick, output, 1: one-cycle pulse per PULSES_PER_UNIT accepted edges.
- wait_tick, output, 1: one-cycle pulse every WAIT_DIV cycles while STOPPED.
- moving, output, 1: high when state is MOVING.
- stopped, output, 1: high when state is STOPPED.
- frac_cnt, output, clog2(PULSES_PER_UNIT), min 1 bit: pulses accumulated toward the next dist_tick.

Behaviour:

Reset (rst=0, asynchronous):
- Synchroniser, debounced level, all counters, FSM=IDLE.
- All outputs 0.
- Takes effect immediately, mid-pulse or mid-unit. No tick may be emitted in the cycle after reset release.

Synchroniser:
- SYNC_STAGES-deep flop chain on motor. The last stage is sync_m.

Debounce:
- deb is the debounced level; stab_cnt counts consecutive cycles where sync_m != deb.
- stab_cnt clears whenever sync_m == deb.
- deb toggles on the edge where stab_cnt reaches DEBOUNCE_CYCLES-1 while sync_m still differs; stab_cnt clears on that edge.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync_m never changes deb.

Edge detect:
- pulse_edge is registered and high for exactly one cycle after deb goes 0->1.
- Latency: motor first sampled high at cycle 0 and held → pulse_edge high in cycle SYNC_STAGES+DEBOUNCE_CYCLES+1 (defaults: cycle 7).
- Falling edges produce no event.
- pulse_edge is suppressed (forced 0) when enable=0.

FSM states: IDLE, STOPPED, MOVING.
- Any state → IDLE when enable=0. Takes priority over every other transition.
- IDLE → STOPPED when enable=1.
- STOPPED → MOVING on accepted pulse_edge.
- MOVING → STOPPED when stall_cnt reaches STALL_CYCLES-1 with no edge in that cycle.

Stall counter:
- Counts clocks in MOVING.
- Clears on every accepted edge and on entering MOVING.
- If an edge and the timeout coincide, the edge wins: remain MOVING and clear stall_cnt.

Distance counting:
- Each accepted pulse_edge increments frac_cnt, including the edge that causes STOPPED → MOVING.
- When frac_cnt == PULSES_PER_UNIT-1 and an edge arrives: frac_cnt → 0 and dist_tick asserts in the same cycle as that pulse_edge.
- frac_cnt clears when enable=0 (new trip). It is retained across STOPPED/MOVING changes.

Wait timing:
- wait_div counts only in STOPPED.
- It clears on entry to STOPPED and on leaving STOPPED; partial periods are discarded.
- wait_tick is high for one cycle when wait_div == WAIT_DIV-1, then wait_div wraps to 0.
- The first tick comes WAIT_DIV cycles after entering STOPPED.

Output rules:
- moving and stopped are registered decodes of the state; they are never both high.
- dist_tick and wait_tick are mutually exclusive by construction. wait_tick is never high in MOVING.
- Counter widths are sized so no counter exceeds its terminal value. No wrap other than the defined terminal wraps.

Test Plan:
- Reset/idle: hold rst=0, toggle motor and enable → all outputs 0. Release rst with enable=0 and pulse motor → no pulse_edge, FSM stays IDLE.
- Latency and debounce (defaults): enable=1, motor 0→1 held → pulse_edge high only in cycle 7, moving=1 from the next cycle. A 3-cycle motor glitch produces no pulse_edge.
- Distance: 25 clean pulses (period 20 cycles) → exactly 2 dist_tick pulses, coincident with the 10th and 20th pulse_edge; frac_cnt=5 at the end. Drop enable → frac_cnt=0 and IDLE.
- Stall/wait (STALL_CYCLES=50, WAIT_DIV=20): one pulse, then silence → STOPPED 50 cycles after the pulse_edge, then wait_tick every 20 cycles. A pulse 30 cycles into STOPPED → MOVING, no wait_tick at cycle 40, divider restarts on the next stop.
- Collision: a pulse_edge landing exactly on the stall timeout cycle → remains MOVING, stall_cnt cleared, no wait_tick.
- Async reset mid-unit: after 7 pulses, assert rst for half a clock period → outputs 0 immediately. After release, 10 pulses are needed for the next dist_tick.
